// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, types and feature defaults
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int NREG_DEF   = 2 ** ADDR_W_DEF;
  localparam int NRD_DEF    = 4;
  localparam int NWR_DEF    = 2;

  localparam bit ZERO_R0_DEF = 1'b1;
  localparam bit BYPASS_DEF  = 1'b1;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - operand-read, writeback and busy-set bundle of the register file
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        bs_en;
  logic [NWR*ADDR_W-1:0] bs_addr;
  logic [NREG-1:0]       busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, bs_en, bs_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, bs_en, bs_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with write-bypass priority mux
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NWR     = NWR_DEF,
  parameter int NREG    = 2 ** ADDR_W,
  parameter bit ZERO_R0 = ZERO_R0_DEF,
  parameter bit BYPASS  = BYPASS_DEF
) (
  input  logic [ADDR_W-1:0]            rd_addr_i,
  input  logic [NREG-1:0][DATA_W-1:0]  regs_i,
  input  logic [NREG-1:0]              busy_i,
  input  logic                         bypass_ok_i,
  input  logic [NWR-1:0]               wr_en_i,
  input  logic [NWR*ADDR_W-1:0]        wr_addr_i,
  input  logic [NWR*DATA_W-1:0]        wr_data_i,
  output logic [DATA_W-1:0]            rd_data_o,
  output logic                         rd_busy_o
);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i];
    // Ascending scan so the highest-indexed matching write port ends up selected.
    if (BYPASS && bypass_ok_i) begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i)) begin
          rd_data_o = wr_data_i[k*DATA_W +: DATA_W];
          rd_busy_o = 1'b0;
        end
      end
    end
    if (ZERO_R0 && (rd_addr_i == '0)) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and busy scoreboard
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int NWR     = NWR_DEF,
  parameter bit ZERO_R0 = ZERO_R0_DEF,
  parameter bit BYPASS  = BYPASS_DEF
) (
  input logic            clock,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREG-1:0]             busy_q, busy_d;
  logic [NRD-1:0][DATA_W-1:0]  rd_data_w;
  logic [NRD-1:0]              rd_busy_w;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Port order gives write priority: a later (higher) port overwrites an earlier one.
    for (int k = 0; k < NWR; k++) begin
      if (bus.wr_en[k]) begin
        if (!(ZERO_R0 && (bus.wr_addr[k*ADDR_W +: ADDR_W] == '0))) begin
          regs_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = bus.wr_data[k*DATA_W +: DATA_W];
        end
        busy_d[bus.wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    // Sets are applied after clears so a fresh dispatch beats a same-cycle writeback.
    for (int k = 0; k < NWR; k++) begin
      if (bus.bs_en[k] && !(ZERO_R0 && (bus.bs_addr[k*ADDR_W +: ADDR_W] == '0))) begin
        busy_d[bus.bs_addr[k*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWR     (NWR),
      .NREG    (NREG),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .rd_addr_i   (bus.rd_addr[j*ADDR_W +: ADDR_W]),
      .regs_i      (regs_q),
      .busy_i      (busy_q),
      .bypass_ok_i (reset),
      .wr_en_i     (bus.wr_en),
      .wr_addr_i   (bus.wr_addr),
      .wr_data_i   (bus.wr_data),
      .rd_data_o   (rd_data_w[j]),
      .rd_busy_o   (rd_busy_w[j])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = rd_busy_w;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed and random checks of regfile_mp_sb against a behavioural model
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(2)) ifa ();
  regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(2)) ifb ();
  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(4), .NRD(6), .NWR(3)) ifc ();

  assign ifb.wr_en   = ifa.wr_en;
  assign ifb.wr_addr = ifa.wr_addr;
  assign ifb.wr_data = ifa.wr_data;
  assign ifb.rd_addr = ifa.rd_addr;
  assign ifb.bs_en   = ifa.bs_en;
  assign ifb.bs_addr = ifa.bs_addr;

  regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(2), .ZERO_R0(1'b1), .BYPASS(1'b1))
    dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
  regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NRD(4), .NWR(2), .ZERO_R0(1'b1), .BYPASS(1'b0))
    dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));
  regfile_mp_sb #(.DATA_W(32), .ADDR_W(4), .NRD(6), .NWR(3), .ZERO_R0(1'b1), .BYPASS(1'b1))
    dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));

  int n_assert = 0;
  int n_fail   = 0;

  // Index 0 models the 8x16 build (shared by dut_a and dut_b), index 1 the 16x32 build.
  logic [31:0] mreg  [2][16];
  logic        mbusy [2][16];
  logic        wen   [2][3];
  logic [3:0]  waddr [2][3];
  logic [31:0] wdata [2][3];
  logic        bsen  [2][3];
  logic [3:0]  bsaddr[2][3];
  logic [3:0]  raddr [2][6];

  function automatic int nwr(int c);  return (c == 0) ? 2 : 3;   endfunction
  function automatic int nrd(int c);  return (c == 0) ? 4 : 6;   endfunction
  function automatic int nreg(int c); return (c == 0) ? 8 : 16;  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        wen[c][k] = 1'b0; waddr[c][k] = '0; wdata[c][k] = '0;
        bsen[c][k] = 1'b0; bsaddr[c][k] = '0;
      end
      for (int j = 0; j < 6; j++) raddr[c][j] = '0;
    end
  endtask

  task automatic setw(int k, bit en, int addr, logic [31:0] data);
    for (int c = 0; c < 2; c++) begin
      if (k < nwr(c)) begin
        wen[c][k]   = en;
        waddr[c][k] = 4'(addr % nreg(c));
        wdata[c][k] = (c == 0) ? {16'h0, data[15:0]} : data;
      end
    end
  endtask

  task automatic setb(int k, bit en, int addr);
    for (int c = 0; c < 2; c++) begin
      if (k < nwr(c)) begin
        bsen[c][k]   = en;
        bsaddr[c][k] = 4'(addr % nreg(c));
      end
    end
  endtask

  task automatic setr(int j, int addr);
    for (int c = 0; c < 2; c++) begin
      if (j < nrd(c)) raddr[c][j] = 4'(addr % nreg(c));
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      ifa.wr_en[k]            = wen[0][k];
      ifa.wr_addr[k*3 +: 3]   = waddr[0][k][2:0];
      ifa.wr_data[k*16 +: 16] = wdata[0][k][15:0];
      ifa.bs_en[k]            = bsen[0][k];
      ifa.bs_addr[k*3 +: 3]   = bsaddr[0][k][2:0];
    end
    for (int j = 0; j < 4; j++) ifa.rd_addr[j*3 +: 3] = raddr[0][j][2:0];
    for (int k = 0; k < 3; k++) begin
      ifc.wr_en[k]            = wen[1][k];
      ifc.wr_addr[k*4 +: 4]   = waddr[1][k];
      ifc.wr_data[k*32 +: 32] = wdata[1][k];
      ifc.bs_en[k]            = bsen[1][k];
      ifc.bs_addr[k*4 +: 4]   = bsaddr[1][k];
    end
    for (int j = 0; j < 6; j++) ifc.rd_addr[j*4 +: 4] = raddr[1][j];
  endtask

  // Returns {busy, data} that a read of port j should show before the coming edge.
  function automatic logic [32:0] exp_rd(int c, int j, bit byp);
    int a;
    a = int'(raddr[c][j]);
    if (a == 0) return 33'd0;
    if (byp && reset) begin
      for (int k = nwr(c) - 1; k >= 0; k--) begin
        if (wen[c][k] && int'(waddr[c][k]) == a) return {1'b0, wdata[c][k]};
      end
    end
    return {mbusy[c][a], mreg[c][a]};
  endfunction

  task automatic model_update();
    bit set_r[16];
    bit clr_r[16];
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        for (int r = 0; r < 16; r++) begin mreg[c][r] = '0; mbusy[c][r] = 1'b0; end
      end else begin
        for (int r = 0; r < 16; r++) begin set_r[r] = 1'b0; clr_r[r] = 1'b0; end
        for (int k = 0; k < nwr(c); k++) begin
          if (wen[c][k]) begin
            if (waddr[c][k] != 0) mreg[c][waddr[c][k]] = wdata[c][k];
            clr_r[waddr[c][k]] = 1'b1;
          end
          if (bsen[c][k] && bsaddr[c][k] != 0) set_r[bsaddr[c][k]] = 1'b1;
        end
        for (int r = 0; r < nreg(c); r++) begin
          mbusy[c][r] = set_r[r] ? 1'b1 : (clr_r[r] ? 1'b0 : mbusy[c][r]);
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_bv(int c);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < nreg(c); r++) v[r] = mbusy[c][r];
    return v;
  endfunction

  task automatic step();
    logic [32:0] e;
    drive();
    @(negedge clock);
    for (int j = 0; j < 4; j++) begin
      e = exp_rd(0, j, 1'b1);
      check($sformatf("a_rd_data[%0d]", j), {16'h0, ifa.rd_data[j*16 +: 16]}, e[31:0]);
      check($sformatf("a_rd_busy[%0d]", j), {31'h0, ifa.rd_busy[j]}, {31'h0, e[32]});
      e = exp_rd(0, j, 1'b0);
      check($sformatf("b_rd_data[%0d]", j), {16'h0, ifb.rd_data[j*16 +: 16]}, e[31:0]);
      check($sformatf("b_rd_busy[%0d]", j), {31'h0, ifb.rd_busy[j]}, {31'h0, e[32]});
    end
    for (int j = 0; j < 6; j++) begin
      e = exp_rd(1, j, 1'b1);
      check($sformatf("c_rd_data[%0d]", j), ifc.rd_data[j*32 +: 32], e[31:0]);
      check($sformatf("c_rd_busy[%0d]", j), {31'h0, ifc.rd_busy[j]}, {31'h0, e[32]});
    end
    @(posedge clock);
    model_update();
    #1;
    check("a_busy_vec", {24'h0, ifa.busy_vec}, exp_bv(0));
    check("b_busy_vec", {24'h0, ifb.busy_vec}, exp_bv(0));
    check("c_busy_vec", {16'h0, ifc.busy_vec}, exp_bv(1));
  endtask

  initial begin
    reset = 1'b0;
    clear_stim();
    drive();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 16; r++) begin mreg[c][r] = '0; mbusy[c][r] = 1'b0; end
    @(posedge clock);
    #1;
    reset = 1'b1;
    check("reset_busy_vec_a", {24'h0, ifa.busy_vec}, 32'h0);
    check("reset_busy_vec_c", {16'h0, ifc.busy_vec}, 32'h0);

    // R3 written, then a reset cycle that also carries a write which must be dropped
    setw(0, 1'b1, 3, 32'h0000_1234); for (int j = 0; j < 6; j++) setr(j, 3); step();
    clear_stim(); setw(0, 1'b1, 3, 32'h0000_DEAD); setb(1, 1'b1, 2); setr(0, 3);
    reset = 1'b0; step();
    reset = 1'b1; clear_stim(); setr(0, 3); setr(1, 2); setr(2, 7); step();
    check("after_reset_r3", {16'h0, ifa.rd_data[15:0]}, 32'h0);

    // same address on both ports, then distinct addresses
    clear_stim(); setw(0, 1'b1, 5, 32'h0000_AAAA); setw(1, 1'b1, 5, 32'h0000_BBBB); step();
    clear_stim(); setr(0, 5); setw(0, 1'b1, 2, 32'h2222_2222); setw(1, 1'b1, 6, 32'h6666_6666); step();
    clear_stim(); setr(0, 5); setr(1, 2); setr(2, 6); step();
    check("dual_write_r5", {16'h0, ifa.rd_data[15:0]}, 32'h0000_BBBB);

    // same-cycle bypass vs. registered view
    clear_stim(); setw(0, 1'b1, 4, 32'h0000_00FF); setr(0, 4); step();
    clear_stim(); setr(0, 4); step();

    // R0 hardwired
    clear_stim(); setw(0, 1'b1, 0, 32'hFFFF_FFFF); setb(0, 1'b1, 0); setr(0, 0); step();
    clear_stim(); setr(0, 0); step();

    // scoreboard set / set-over-clear / clear
    clear_stim(); setb(0, 1'b1, 7); step();
    check("sb_set_r7", {24'h0, ifa.busy_vec}, 32'h80);
    clear_stim(); setr(0, 7); setw(1, 1'b1, 7, 32'h0000_7777); setb(0, 1'b1, 7); step();
    clear_stim(); setr(0, 7); step();
    clear_stim(); setw(0, 1'b1, 7, 32'h0000_0707); setr(1, 7); step();
    check("sb_clear_r7", {24'h0, ifa.busy_vec}, 32'h0);

    // top register, three ports (8x16 build sees R7 on two ports)
    clear_stim(); setw(0, 1'b1, 15, 32'h1111_0000); setw(1, 1'b1, 15, 32'h2222_0001);
    setw(2, 1'b1, 15, 32'h3333_0002); setr(0, 15); step();
    clear_stim(); setr(0, 15); setr(5, 15); step();
    check("three_way_r15", ifc.rd_data[31:0], 32'h3333_0002);

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < nwr(c); k++) begin
          wen[c][k]    = 1'($urandom_range(0, 1));
          waddr[c][k]  = 4'($urandom_range(0, nreg(c) - 1));
          wdata[c][k]  = (c == 0) ? {16'h0, 16'($urandom)} : 32'($urandom);
          bsen[c][k]   = ($urandom_range(0, 2) == 0);
          bsaddr[c][k] = 4'($urandom_range(0, nreg(c) - 1));
        end
        for (int j = 0; j < nrd(c); j++) raddr[c][j] = 4'($urandom_range(0, nreg(c) - 1));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
